// File: rtl/compare_search_pkg.sv
// -----------------------------------------------------------------------------
// compare_search_pkg
// Shared definitions for the compare_search binary-search controller:
//   - state_e : controller states IDLE / SETTLE / EVAL / FINISH
//   - FLAG_*  : comparator flag-vector encoding, packed as {lt, eq, gt}
// -----------------------------------------------------------------------------
package compare_search_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EVAL   = 2'd2,
        FINISH = 2'd3
    } state_e;

    // Flag vector {a_less_b, a_equal_b, a_greater_b}
    localparam logic [2:0] FLAG_LT = 3'b100;
    localparam logic [2:0] FLAG_EQ = 3'b010;
    localparam logic [2:0] FLAG_GT = 3'b001;

endpackage

// File: rtl/compare_search.sv
// -----------------------------------------------------------------------------
// compare_search
// Binary search of an unknown target using an external magnitude comparator.
// The controller drives a trial value on probe, waits CMP_LAT settle cycles,
// samples the comparator flags once and narrows the [lo, hi] window until the
// comparator reports equality or the answer becomes impossible.
//
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   start        : begin a new search (accepted only in IDLE)
//   probe        : registered trial value for the comparator a operand
//   a_less_b     : comparator flag, probe <  target
//   a_equal_b    : comparator flag, probe == target
//   a_greater_b  : comparator flag, probe >  target
//   busy         : high whenever not IDLE
//   done         : one-cycle completion pulse (FINISH)
//   result       : value found, held until next accepted start
//   error        : search aborted, held until next accepted start
//   steps        : number of EVAL cycles of the last search
// -----------------------------------------------------------------------------
module compare_search
    import compare_search_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CMP_LAT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic [WIDTH-1:0]               probe,
    input  logic                           a_less_b,
    input  logic                           a_equal_b,
    input  logic                           a_greater_b,
    output logic                           busy,
    output logic                           done,
    output logic [WIDTH-1:0]               result,
    output logic                           error,
    output logic [$clog2(WIDTH+2)-1:0]     steps
);

    localparam int          SW          = $clog2(WIDTH + 2);
    localparam logic [WIDTH:0] MAXV     = {1'b0, {WIDTH{1'b1}}};
    localparam int unsigned SETTLE_LAST = (CMP_LAT > 0) ? CMP_LAT - 1 : 0;
    localparam logic [1:0]  CNT_LAST    = 2'(SETTLE_LAST);

    state_e             r_state,  w_state_nxt;
    logic [WIDTH:0]     r_lo,     w_lo_nxt;
    logic [WIDTH:0]     r_hi,     w_hi_nxt;
    logic [WIDTH-1:0]   r_probe,  w_probe_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_error,  w_error_nxt;
    logic [SW-1:0]      r_steps,  w_steps_nxt;
    logic [1:0]         r_cnt,    w_cnt_nxt;

    logic [2:0]         w_flags;
    logic [WIDTH:0]     w_probe_ext;
    logic [WIDTH:0]     w_up_lo;
    logic [WIDTH:0]     w_up_hi;

    // Midpoint of a non-empty window; never exceeds hi so it fits WIDTH bits.
    function automatic logic [WIDTH-1:0] mid(input logic [WIDTH:0] lo,
                                             input logic [WIDTH:0] hi);
        logic [WIDTH:0] m;
        m = lo + ((hi - lo) >> 1);
        return m[WIDTH-1:0];
    endfunction

    // State entered after every probe load.
    function automatic state_e after_probe();
        if (CMP_LAT > 0)
            return SETTLE;
        return EVAL;
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_lo_nxt     = r_lo;
        w_hi_nxt     = r_hi;
        w_probe_nxt  = r_probe;
        w_result_nxt = r_result;
        w_error_nxt  = r_error;
        w_steps_nxt  = r_steps;
        w_cnt_nxt    = r_cnt;

        w_flags     = {a_less_b, a_equal_b, a_greater_b};
        w_probe_ext = {1'b0, r_probe};
        w_up_lo     = w_probe_ext + 1'b1;
        // Wraps when probe is 0, but that case is rejected before use.
        w_up_hi     = w_probe_ext - 1'b1;

        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_lo_nxt     = '0;
                    w_hi_nxt     = MAXV;
                    w_probe_nxt  = mid('0, MAXV);
                    w_result_nxt = '0;
                    w_error_nxt  = 1'b0;
                    w_steps_nxt  = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = after_probe();
                end
            end

            SETTLE: begin
                if (r_cnt == CNT_LAST)
                    w_state_nxt = EVAL;
                else
                    w_cnt_nxt = r_cnt + 2'd1;
            end

            EVAL: begin
                w_steps_nxt = r_steps + SW'(1);
                w_cnt_nxt   = '0;
                case (w_flags)
                    FLAG_EQ: begin
                        w_result_nxt = r_probe;
                        w_state_nxt  = FINISH;
                    end
                    FLAG_LT: begin
                        if ((w_probe_ext == MAXV) || (w_up_lo > r_hi)) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = FINISH;
                        end else begin
                            w_lo_nxt    = w_up_lo;
                            w_probe_nxt = mid(w_up_lo, r_hi);
                            w_state_nxt = after_probe();
                        end
                    end
                    FLAG_GT: begin
                        if ((r_probe == '0) || (r_lo > w_up_hi)) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = FINISH;
                        end else begin
                            w_hi_nxt    = w_up_hi;
                            w_probe_nxt = mid(r_lo, w_up_hi);
                            w_state_nxt = after_probe();
                        end
                    end
                    default: begin
                        // Flags not one-hot: comparator is inconsistent.
                        w_error_nxt = 1'b1;
                        w_state_nxt = FINISH;
                    end
                endcase
            end

            FINISH: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_lo     <= '0;
            r_hi     <= '0;
            r_probe  <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_steps  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_lo     <= w_lo_nxt;
            r_hi     <= w_hi_nxt;
            r_probe  <= w_probe_nxt;
            r_result <= w_result_nxt;
            r_error  <= w_error_nxt;
            r_steps  <= w_steps_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign probe  = r_probe;
    assign busy   = (r_state != IDLE);
    assign done   = (r_state == FINISH);
    assign result = r_result;
    assign error  = r_error;
    assign steps  = r_steps;

endmodule
